// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared definitions for the score_counter block: the score width, the
// milestone step and its sub-counter width, and the game-round state
// encoding.
// ---------------------------------------------------------------------------
package score_pkg;

   localparam int SCORE_W        = 13;
   localparam int MILESTONE_STEP = 100;
   localparam int SUB_W          = 7;   // holds 0..MILESTONE_STEP-1

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OVER = 2'd2
   } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Wrapping counter 0..TICK_DIV-1. While en is high it advances every cycle
// and tick is high during the cycle in which it wraps. clr forces the count
// back to 0 and has priority over en. TICK_DIV must be >= 2.
//
// Ports:
//   clk2   in   system clock, rising edge
//   reset  in   asynchronous, active-low reset
//   clr    in   synchronous clear of the count (priority over en)
//   en     in   count enable
//   tick   out  high in the wrap cycle while en is high
// ---------------------------------------------------------------------------
module tick_prescaler #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk2,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int               CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // NOTE: every combinational output gets a default before any branch;
   // a path that leaves it unassigned would infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/score_counter.sv
// ---------------------------------------------------------------------------
// score_counter
// Game-round state machine and score generator feeding the score display.
// A start rising edge begins a round (score cleared); each prescaler tick
// adds one point up to SCORE_MAX; a hit ends the round and freezes the
// score. Every nonzero multiple of 100 reached gives a one-cycle milestone
// pulse, coincident with the new score becoming visible.
//
// Optional feature macro: SCORE_HISCORE_EN
//   defined   - session high score register, updated on RUN->OVER
//   undefined - hiscore tied to zero, no compare logic
//
// Ports:
//   clk2       in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   level; rising edge starts a round from IDLE or OVER
//   hit        in   level collision flag, acted on only in RUN
//   score      out  current score (13 bits, unsigned)
//   hiscore    out  best score of the session (13 bits)
//   running    out  high while in RUN
//   game_over  out  high while in OVER
//   milestone  out  one-cycle pulse on reaching a nonzero multiple of 100
// ---------------------------------------------------------------------------
module score_counter
   import score_pkg::*;
#(
   parameter int TICK_DIV  = 50000,
   parameter int SCORE_MAX = 6399
) (
   input  logic               clk2,
   input  logic               reset,
   input  logic               start,
   input  logic               hit,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] hiscore,
   output logic               running,
   output logic               game_over,
   output logic               milestone
);

   localparam logic [SCORE_W-1:0] SCORE_MAX_C = SCORE_W'(SCORE_MAX);
   localparam logic [SUB_W-1:0]   SUB_LAST    = SUB_W'(MILESTONE_STEP - 1);

   state_e             state_q, state_d;
   logic               start_q;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SUB_W-1:0]   sub_q, sub_d;
   logic               milestone_q, milestone_d;

   logic start_rise;
   logic enter_run;
   logic tick;

   assign start_rise = start & ~start_q;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk2  (clk2),
      .reset (reset),
      .clr   (enter_run),
      .en    (state_q == S_RUN),
      .tick  (tick)
   );

   // Round state machine; start_rise in RUN and hit outside RUN are ignored.
   always_comb begin
      state_d   = state_q;
      enter_run = 1'b0;
      unique case (state_q)
         S_IDLE, S_OVER: begin
            if (start_rise) begin
               state_d   = S_RUN;
               enter_run = 1'b1;
            end
         end
         S_RUN: begin
            if (hit) state_d = S_OVER;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Score and hundreds sub-counter. A hit in a tick cycle suppresses the
   // increment; at SCORE_MAX the sub-counter stops too, so no milestones.
   always_comb begin
      score_d     = score_q;
      sub_d       = sub_q;
      milestone_d = 1'b0;
      if (enter_run) begin
         score_d = '0;
         sub_d   = '0;
      end else if (state_q == S_RUN && tick && !hit && score_q < SCORE_MAX_C) begin
         score_d = score_q + SCORE_W'(1);
         if (sub_q == SUB_LAST) begin
            sub_d       = '0;
            milestone_d = 1'b1;
         end else begin
            sub_d = sub_q + SUB_W'(1);
         end
      end
   end

   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b0;
         score_q     <= '0;
         sub_q       <= '0;
         milestone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start;
         score_q     <= score_d;
         sub_q       <= sub_d;
         milestone_q <= milestone_d;
      end
   end

`ifdef SCORE_HISCORE_EN
   logic [SCORE_W-1:0] hiscore_q, hiscore_d;

   // Captured on the RUN->OVER cycle; score is frozen there, so score_q is
   // the final score of the round.
   always_comb begin
      hiscore_d = hiscore_q;
      if (state_q == S_RUN && hit && score_q > hiscore_q) begin
         hiscore_d = score_q;
      end
   end

   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset) begin
         hiscore_q <= '0;
      end else begin
         hiscore_q <= hiscore_d;
      end
   end

   assign hiscore = hiscore_q;
`else
   assign hiscore = '0;
`endif

   assign score     = score_q;
   assign running   = (state_q == S_RUN);
   assign game_over = (state_q == S_OVER);
   assign milestone = milestone_q;

endmodule

// File: tb/tb_score_counter.sv
// ---------------------------------------------------------------------------
// tb_score_counter
// Self-checking bench for score_counter (TICK_DIV=4, SCORE_MAX=205).
// The reference model tracks the number of non-hit RUN cycles in the round
// and derives the score as min(cycles / TICK_DIV, SCORE_MAX). Honours
// SCORE_HISCORE_EN for the expected high score.
// ---------------------------------------------------------------------------
module tb_score_counter;
   import score_pkg::*;

   localparam int TD   = 4;
   localparam int SMAX = 205;

   logic               clk2 = 1'b0;
   logic               reset;
   logic               start;
   logic               hit;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] hiscore;
   logic               running;
   logic               game_over;
   logic               milestone;

   int n_cmp  = 0;
   int n_fail = 0;
   int ms_seen = 0;

   // Reference model: mode 0 idle, 1 run, 2 over
   int m_mode, m_k, m_score, m_hi;
   bit m_prev, m_ms;

   typedef struct {
      bit s;
      bit h;
      int n;
      int score;
      bit run;
      bit over;
      int hi;
   } vec_t;

   vec_t vecs [8];

   score_counter #(
      .TICK_DIV  (TD),
      .SCORE_MAX (SMAX)
   ) dut (
      .clk2      (clk2),
      .reset     (reset),
      .start     (start),
      .hit       (hit),
      .score     (score),
      .hiscore   (hiscore),
      .running   (running),
      .game_over (game_over),
      .milestone (milestone)
   );

   always #5 clk2 = ~clk2;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int hs(input int v);
`ifdef SCORE_HISCORE_EN
      return v;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_k     = 0;
      m_score = 0;
      m_hi    = 0;
      m_prev  = 1'b0;
      m_ms    = 1'b0;
   endtask

   task automatic model_edge(input bit s, input bit h);
      bit rise;
      int nxt;
      rise   = s && !m_prev;
      m_prev = s;
      m_ms   = 1'b0;
      case (m_mode)
         1: begin
            if (h) begin
               if (m_score > m_hi) m_hi = m_score;
               m_mode = 2;
            end else begin
               m_k++;
               nxt = m_k / TD;
               if (nxt > SMAX) nxt = SMAX;
               m_ms    = (nxt != m_score) && (nxt % MILESTONE_STEP == 0);
               m_score = nxt;
            end
         end
         default: begin
            if (rise) begin
               m_mode  = 1;
               m_k     = 0;
               m_score = 0;
            end
         end
      endcase
   endtask

   task automatic check_all(input string tag);
      check({tag, ".score"},     score,     m_score);
      check({tag, ".hiscore"},   hiscore,   hs(m_hi));
      check({tag, ".running"},   running,   m_mode == 1);
      check({tag, ".game_over"}, game_over, m_mode == 2);
      check({tag, ".milestone"}, milestone, m_ms);
   endtask

   // One clock cycle with the given inputs; outputs sampled 1 time unit
   // after the rising edge.
   task automatic cyc(input bit s, input bit h);
      start = s;
      hit   = h;
      @(posedge clk2);
      model_edge(s, h);
      #1;
      if (milestone === 1'b1) ms_seen++;
      check_all("cyc");
   endtask

   task automatic reset_dut();
      start = 1'b0;
      hit   = 1'b0;
      reset = 1'b0;
      @(posedge clk2);
      #1;
      reset = 1'b1;
      model_reset();
      check_all("rst");
   endtask

   initial begin
      int guard;
      bit s;

      //           s  h  n   score run over hi
      vecs[0] = '{1, 0, 1,  0,    1,  0,   0};
      vecs[1] = '{0, 0, 3,  0,    1,  0,   0};
      vecs[2] = '{0, 0, 1,  1,    1,  0,   0};
      vecs[3] = '{0, 0, 16, 5,    1,  0,   0};
      vecs[4] = '{0, 1, 1,  5,    0,  1,   5};
      vecs[5] = '{0, 0, 3,  5,    0,  1,   5};
      vecs[6] = '{1, 1, 1,  0,    1,  0,   5};
      vecs[7] = '{1, 0, 6,  1,    1,  0,   5};

      model_reset();
      start = 1'b0;
      hit   = 1'b0;
      reset = 1'b0;
      #13;
      check("reset.score",     score,     0);
      check("reset.hiscore",   hiscore,   0);
      check("reset.running",   running,   0);
      check("reset.game_over", game_over, 0);
      check("reset.milestone", milestone, 0);
      reset = 1'b1;

      // Table-driven basic round
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < vecs[i].n; j++) cyc(vecs[i].s, vecs[i].h);
         check($sformatf("vec%0d.score", i),     score,     vecs[i].score);
         check($sformatf("vec%0d.running", i),   running,   vecs[i].run);
         check($sformatf("vec%0d.game_over", i), game_over, vecs[i].over);
         check($sformatf("vec%0d.hiscore", i),   hiscore,   hs(vecs[i].hi));
      end

      // Milestone at 100 only
      reset_dut();
      cyc(1, 0);
      check("ms.at0", milestone, 0);
      ms_seen = 0;
      guard = 0;
      while (m_score < 99 && guard < 1000) begin cyc(0, 0); guard++; end
      check("ms.score99", score, 99);
      check("ms.none_before", ms_seen, 0);
      guard = 0;
      while (m_score < 100 && guard < 10) begin cyc(0, 0); guard++; end
      check("ms.score100", score, 100);
      check("ms.pulse100", milestone, 1);
      cyc(0, 0);
      check("ms.pulse_one_cycle", milestone, 0);
      guard = 0;
      while (m_score < 101 && guard < 10) begin cyc(0, 0); guard++; end
      check("ms.score101", score, 101);
      check("ms.count_to101", ms_seen, 1);

      // Hit exactly on the tick at 37, then restart
      reset_dut();
      cyc(1, 0);
      guard = 0;
      while (m_k < 37 * TD + TD - 1 && guard < 1000) begin cyc(0, 0); guard++; end
      check("hit37.pre", score, 37);
      cyc(0, 1);
      check("hit37.score", score, 37);
      check("hit37.over", game_over, 1);
      check("hit37.hi", hiscore, hs(37));
      cyc(0, 0);
      cyc(1, 0);
      check("hit37.restart_score", score, 0);
      check("hit37.restart_run", running, 1);
      check("hit37.restart_hi", hiscore, hs(37));

      // Saturation at SCORE_MAX; milestones at 100 and 200 only
      ms_seen = 0;
      for (int i = 0; i < 900; i++) cyc(0, 0);
      check("sat.score", score, SMAX);
      check("sat.milestones", ms_seen, 2);
      cyc(0, 1);
      check("sat.hi", hiscore, hs(SMAX));

      // start held high: a single round; held into OVER does not restart
      for (int i = 0; i < 50; i++) cyc(1, 0);
      cyc(1, 1);
      check("held.one_round_score", score, 12);
      check("held.over", game_over, 1);
      for (int i = 0; i < 5; i++) cyc(1, 0);
      check("held.no_restart", game_over, 1);
      cyc(0, 0);
      cyc(1, 0);
      check("held.rerise_run", running, 1);
      check("held.rerise_score", score, 0);

      // Randomised traffic against the model
      s = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) s = ~s;
         cyc(s, $urandom_range(0, 99) == 0);
      end

      // Asynchronous reset mid-round at score 12
      cyc(0, 0);
      cyc(0, 1);
      cyc(0, 0);
      cyc(1, 0);
      cyc(0, 0);
      guard = 0;
      while (m_score < 12 && guard < 200) begin cyc(0, 0); guard++; end
      check("areset.pre", score, 12);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("areset.score",     score,     0);
      check("areset.hiscore",   hiscore,   0);
      check("areset.running",   running,   0);
      check("areset.game_over", game_over, 0);
      @(posedge clk2);
      #1;
      check("areset.hold_score", score, 0);
      reset = 1'b1;
      cyc(0, 0);
      check("areset.idle_run",  running,   0);
      check("areset.idle_over", game_over, 0);
      cyc(1, 0);
      check("areset.start_run", running, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
